// File: rtl/cim_tiled_mac_engine.sv
// Tiled compute-in-memory MAC engine: accumulates LANES products per accepted beat
// onto a bias, then presents the full-precision sum and a shifted/saturated/ReLU'd byte.
module cim_tiled_mac_engine #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 5,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  input  logic                          cfg_signed,
  input  logic                          cfg_relu,
  input  logic [4:0]                    cfg_shift,
  input  logic [ACC_WIDTH-1:0]          cfg_bias,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [LANES*DATA_WIDTH-1:0]   in_weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_acc,
  output logic [OUT_WIDTH-1:0]          out_q,
  output logic                          out_ovf,
  output logic                          busy
);

  // Operands are widened by one bit so signed and unsigned share one signed multiplier.
  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   ovf_q, ovf_d;
  logic                   signed_q, signed_d;
  logic                   relu_q, relu_d;
  logic [4:0]             shift_q, shift_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;
  logic [OUT_WIDTH-1:0]   out_q_q, out_q_d;
  logic                   out_ovf_q, out_ovf_d;

  logic signed [PW-1:0]   a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]   beat_sum, acc_sum;
  logic [LEN_WIDTH-1:0]   count_inc;
  logic                   add_ovf, accept;

  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [4:0] sh,
                                                   input logic relu);
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]        res;
    shifted = $signed(acc) >>> sh;
    if (shifted > Q_MAX)      res = Q_MAX[OUT_WIDTH-1:0];
    else if (shifted < Q_MIN) res = Q_MIN[OUT_WIDTH-1:0];
    else                      res = shifted[OUT_WIDTH-1:0];
    if (relu && res[OUT_WIDTH-1]) res = '0;
    return res;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    beat_sum = '0;
    a_ext    = '0;
    b_ext    = '0;
    prod     = '0;
    for (int k = 0; k < LANES; k++) begin
      a_ext = {{(PW-DATA_WIDTH){signed_q & in_data[k*DATA_WIDTH+DATA_WIDTH-1]}},
               in_data[k*DATA_WIDTH +: DATA_WIDTH]};
      b_ext = {{(PW-DATA_WIDTH){signed_q & in_weight[k*DATA_WIDTH+DATA_WIDTH-1]}},
               in_weight[k*DATA_WIDTH +: DATA_WIDTH]};
      prod     = a_ext * b_ext;
      beat_sum = beat_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end
  end

  assign acc_sum   = acc_q + beat_sum;
  assign add_ovf   = (acc_q[ACC_WIDTH-1] == beat_sum[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign count_inc = count_q + LEN_WIDTH'(1);
  assign accept    = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    signed_d    = signed_q;
    relu_d      = relu_q;
    shift_d     = shift_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_q_d     = out_q_q;
    out_ovf_d   = out_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = cfg_bias;
          ovf_d    = 1'b0;
          count_d  = '0;
          len_d    = cfg_len;
          signed_d = cfg_signed;
          relu_d   = cfg_relu;
          shift_d  = cfg_shift;
          busy_d   = 1'b1;
          if (cfg_len == '0) begin
            // Zero-length job: the bias alone is the result.
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_acc_d   = cfg_bias;
            out_q_d     = requant(cfg_bias, cfg_shift, cfg_relu);
            out_ovf_d   = 1'b0;
          end else begin
            state_d    = ACCUM;
            in_ready_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_sum;
          ovf_d   = ovf_q | add_ovf;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d     = DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_acc_d   = acc_sum;
            out_q_d     = requant(acc_sum, shift_q, relu_q);
            out_ovf_d   = ovf_q | add_ovf;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop is reset,
  // including the latched configuration, so a job aborted by reset leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      signed_q    <= 1'b0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_q_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      signed_q    <= signed_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_q_q     <= out_q_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_q     = out_q_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cim_tiled_mac_engine.sv
// Directed scoreboard bench for cim_tiled_mac_engine: stimulus pushes hand-computed
// results, a negedge monitor compares them whenever out_valid is high.
module tb_cim_tiled_mac_engine;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int LW    = 5;
  localparam int OW    = 8;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_signed = 1'b0;
  logic          cfg_relu = 1'b0;
  logic [4:0]    cfg_shift = '0;
  logic [AW-1:0] cfg_bias = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic [VW-1:0] in_weight = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_acc;
  logic [OW-1:0] out_q;
  logic          out_ovf;
  logic          busy;

  typedef struct {
    logic [AW-1:0] acc;
    logic [OW-1:0] q;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cim_tiled_mac_engine #(
    .LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .cfg_signed(cfg_signed), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .cfg_bias(cfg_bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_q(out_q),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid cycle must match the head of the scoreboard (this also
  // proves stability while out_ready is low); the head is retired on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got acc %0h with no job pending", out_acc);
      end else begin
        check("out_acc", {32'd0, out_acc}, {32'd0, sb[0].acc});
        check("out_q",   {56'd0, out_q},   {56'd0, sb[0].q});
        check("out_ovf", {63'd0, out_ovf}, {63'd0, sb[0].ovf});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] acc, input logic [OW-1:0] q, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.q   = q;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic scramble_cfg();
    cfg_len    = LW'($urandom);
    cfg_signed = 1'($urandom);
    cfg_relu   = 1'($urandom);
    cfg_shift  = 5'($urandom);
    cfg_bias   = $urandom;
  endtask

  task automatic start_job(input logic [LW-1:0] len, input logic sgn, input logic relu,
                           input logic [4:0] sh, input logic [AW-1:0] bias);
    cfg_len    = len;
    cfg_signed = sgn;
    cfg_relu   = relu;
    cfg_shift  = sh;
    cfg_bias   = bias;
    start      = 1'b1;
    tick();
    start = 1'b0;
    scramble_cfg();
  endtask

  task automatic send_beat(input logic [VW-1:0] d, input logic [VW-1:0] w);
    logic rdy;
    int   n;
    in_data   = d;
    in_weight = w;
    in_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("beat_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid  = 1'b0;
    in_data   = {4{$urandom}};
    in_weight = {4{$urandom}};
  endtask

  // Idle cycles with in_valid low; optionally poke start with a zero-length config.
  task automatic stall(input int n, input logic poke);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      if (poke) begin
        start    = 1'($urandom);
        cfg_len  = '0;
        cfg_bias = $urandom;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic wait_done(input int hold);
    int n;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 64'd0, 64'd1);
      sb.delete();
    end
    out_ready = 1'b0;
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("out_valid_drop",  {63'd0, out_valid}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_busy"},      {63'd0, busy},      64'd0);
    check({tag, "_out_acc"},   {32'd0, out_acc},   64'd0);
    check({tag, "_out_q"},     {56'd0, out_q},     64'd0);
    check({tag, "_out_ovf"},   {63'd0, out_ovf},   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] d, w;

    #1;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // All-ones, 16 beats: 16 lanes x 16 beats = 256, saturates to 127.
    push_exp(32'd256, 8'h7F, 1'b0);
    start_job(5'd16, 1'b0, 1'b0, 5'd0, 32'd0);
    check("in_ready_accum", {63'd0, in_ready}, 64'd1);
    check("busy_accum",     {63'd0, busy},     64'd1);
    for (int b = 0; b < 16; b++) send_beat({LANES{8'h01}}, {LANES{8'h01}});
    wait_done(0);

    // Lane k carries k*k: sum 1240; shift 0 saturates, shift 4 gives 77.
    for (int k = 0; k < LANES; k++) d[k*DW +: DW] = DW'(k);
    push_exp(32'd1240, 8'h7F, 1'b0);
    start_job(5'd1, 1'b0, 1'b0, 5'd0, 32'd0);
    send_beat(d, d);
    wait_done(0);
    push_exp(32'd1240, 8'd77, 1'b0);
    start_job(5'd1, 1'b0, 1'b0, 5'd4, 32'd0);
    send_beat(d, d);
    wait_done(0);

    // Signed: 8 lanes of 10 * -5 plus bias 100 = -300.
    d = '0;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      d[k*DW +: DW] = 8'd10;
      w[k*DW +: DW] = 8'hFB;
    end
    push_exp(32'hFFFF_FED4, 8'h80, 1'b0);
    start_job(5'd1, 1'b1, 1'b0, 5'd0, 32'd100);
    send_beat(d, w);
    wait_done(0);
    push_exp(32'hFFFF_FED4, 8'h00, 1'b0);
    start_job(5'd1, 1'b1, 1'b1, 5'd0, 32'd100);
    send_beat(d, w);
    wait_done(0);

    // 0xFF * 0xFF: 65025 unsigned, 1 signed.
    d = '0;
    d[3*DW +: DW] = 8'hFF;
    push_exp(32'd65025, 8'h7F, 1'b0);
    start_job(5'd1, 1'b0, 1'b0, 5'd0, 32'd0);
    send_beat(d, d);
    wait_done(0);
    push_exp(32'd1, 8'd1, 1'b0);
    start_job(5'd1, 1'b1, 1'b0, 5'd0, 32'd0);
    send_beat(d, d);
    wait_done(0);

    // Zero-length job: bias 300 >>> 1 = 150, saturates.
    push_exp(32'd300, 8'h7F, 1'b0);
    start_job(5'd0, 1'b0, 1'b0, 5'd1, 32'd300);
    wait_done(0);

    // Three beats with stalls and stray start pulses, result held 5 cycles:
    // 5 + 16*6 + 100*100 + 7*9 = 10164; >>> 7 = 79.
    push_exp(32'd10164, 8'd79, 1'b0);
    start_job(5'd3, 1'b1, 1'b0, 5'd7, 32'd5);
    stall($urandom_range(1, 3), 1'b1);
    send_beat({LANES{8'd2}}, {LANES{8'd3}});
    stall($urandom_range(1, 3), 1'b1);
    d = '0;
    d[0 +: DW] = 8'd100;
    send_beat(d, d);
    stall($urandom_range(1, 3), 1'b1);
    d = '0;
    w = '0;
    d[15*DW +: DW] = 8'd7;
    w[15*DW +: DW] = 8'd9;
    send_beat(d, w);
    stall(2, 1'b1);
    wait_done(5);

    // Signed overflow: 0x7FFFFFFF + 1 wraps, flag sets, result saturates low.
    d = '0;
    d[5*DW +: DW] = 8'd1;
    push_exp(32'h8000_0000, 8'h80, 1'b1);
    start_job(5'd1, 1'b1, 1'b0, 5'd0, 32'h7FFF_FFFF);
    send_beat(d, d);
    wait_done(0);

    // Reset after beat 2 of 4: job discarded, no result may follow.
    start_job(5'd4, 1'b0, 1'b0, 5'd0, 32'd9);
    send_beat({LANES{8'd1}}, {LANES{8'd1}});
    send_beat({LANES{8'd1}}, {LANES{8'd1}});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    tick();
    rst_n = 1'b1;
    stall(10, 1'b0);
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    // Recovery job: bias -2 + 3*4 = 10.
    d = '0;
    w = '0;
    d[0 +: DW] = 8'd3;
    w[0 +: DW] = 8'd4;
    push_exp(32'd10, 8'd10, 1'b0);
    start_job(5'd1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFE);
    send_beat(d, w);
    wait_done(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
